// File: rtl/ipf_lcu_feeder_pkg.sv
// Shared definitions for the LCU feeder: frame geometry, size codes,
// parameter-word layout and FSM states.
package ipf_pkg;
    localparam int IMG_W    = 128;
    localparam int ADDR_W   = 14;
    localparam int PARAM_AW = 6;
    localparam int PIX_W    = 8;
    localparam int PQ_W     = 24;

    localparam int PQ_TYPE_LSB = 22;
    localparam int PQ_TYPE_W   = 2;
    localparam int PQ_BAND_LSB = 17;
    localparam int PQ_BAND_W   = 5;
    localparam int PQ_WO_BIT   = 16;
    localparam int PQ_OFF_LSB  = 0;
    localparam int PQ_OFF_W    = 16;

    typedef enum logic [1:0] {
        LCU16 = 2'b00,
        LCU32 = 2'b01,
        LCU64 = 2'b10
    } lcu_size_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PFETCH = 3'd1,
        S_PLOAD  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // Code 11 has no LCU of its own and runs as 64x64.
    function automatic lcu_size_e size_norm(input logic [1:0] code);
        case (code)
            2'b00:   return LCU16;
            2'b01:   return LCU32;
            default: return LCU64;
        endcase
    endfunction

    function automatic logic [5:0] s_max(input lcu_size_e sz);
        case (sz)
            LCU16:   return 6'd15;
            LCU32:   return 6'd31;
            default: return 6'd63;
        endcase
    endfunction

    function automatic logic [2:0] n_max(input lcu_size_e sz);
        case (sz)
            LCU16:   return 3'd7;
            LCU32:   return 3'd3;
            default: return 3'd1;
        endcase
    endfunction
endpackage

// File: rtl/ipf_lcu_feeder_if.sv
// Feeder bus: image/parameter SRAM read ports, control and the filter input port.
interface ipf_lcu_feeder_if;
    import ipf_pkg::*;

    logic                start;
    logic [1:0]          cfg_lcu_size;
    logic                img_rd;
    logic [ADDR_W-1:0]   img_addr;
    logic [PIX_W-1:0]    img_q;
    logic                param_rd;
    logic [PARAM_AW-1:0] param_addr;
    logic [PQ_W-1:0]     param_q;
    logic                busy;
    logic                in_en;
    logic [PIX_W-1:0]    din;
    logic [1:0]          ipf_type;
    logic [4:0]          ipf_band_pos;
    logic                ipf_wo_class;
    logic [15:0]         ipf_offset;
    logic [2:0]          lcu_x;
    logic [2:0]          lcu_y;
    logic [1:0]          lcu_size;
    logic                done;

    modport master (
        input  start, cfg_lcu_size, img_q, param_q, busy,
        output img_rd, img_addr, param_rd, param_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size, done
    );

    modport slave (
        output start, cfg_lcu_size, img_q, param_q, busy,
        input  img_rd, img_addr, param_rd, param_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size, done
    );
endinterface

// File: rtl/ipf_lcu_feeder_addr_gen.sv
// Pixel/LCU position counters with wrap detection; forms the image SRAM
// address and the parameter index of the following LCU by concatenation.
module ipf_lcu_addr_gen
    import ipf_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  lcu_size_e           size,
    input  logic                clr,
    input  logic                adv,
    output logic [2:0]          lcu_x,
    output logic [2:0]          lcu_y,
    output logic                end_lcu,
    output logic                end_frame,
    output logic [ADDR_W-1:0]   pix_addr,
    output logic [PARAM_AW-1:0] nxt_idx
);
    localparam int COL_W = $clog2(IMG_W);

    logic [5:0]       col_r;
    logic [5:0]       row_r;
    logic [2:0]       x_r;
    logic [2:0]       y_r;
    logic             end_row_s;
    logic             last_x_s;
    logic [2:0]       nx_s;
    logic [2:0]       ny_s;
    logic [COL_W-1:0] row_abs_s;
    logic [COL_W-1:0] col_abs_s;

    assign end_row_s = (col_r == s_max(size));
    assign end_lcu   = end_row_s && (row_r == s_max(size));
    assign last_x_s  = (x_r == n_max(size));
    assign end_frame = end_lcu && last_x_s && (y_r == n_max(size));
    assign nx_s      = last_x_s ? 3'd0 : (x_r + 3'd1);
    assign ny_s      = last_x_s ? (y_r + 3'd1) : y_r;
    assign lcu_x     = x_r;
    assign lcu_y     = y_r;
    assign pix_addr  = {row_abs_s, col_abs_s};

    // LCU index bits sit above the in-LCU offset bits, so positions are pure concatenations.
    always_comb begin
        row_abs_s = '0;
        col_abs_s = '0;
        nxt_idx   = '0;
        case (size)
            LCU16: begin
                row_abs_s = {y_r, row_r[3:0]};
                col_abs_s = {x_r, col_r[3:0]};
                nxt_idx   = {ny_s, nx_s};
            end
            LCU32: begin
                row_abs_s = {y_r[1:0], row_r[4:0]};
                col_abs_s = {x_r[1:0], col_r[4:0]};
                nxt_idx   = {2'b00, ny_s[1:0], nx_s[1:0]};
            end
            default: begin
                row_abs_s = {y_r[0], row_r[5:0]};
                col_abs_s = {x_r[0], col_r[5:0]};
                nxt_idx   = {4'b0000, ny_s[0], nx_s[0]};
            end
        endcase
    end

    // Raster walk: col, then row, then LCU column, then LCU row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_r <= 6'd0;
            row_r <= 6'd0;
            x_r   <= 3'd0;
            y_r   <= 3'd0;
        end else if (clr || (adv && end_frame)) begin
            col_r <= 6'd0;
            row_r <= 6'd0;
            x_r   <= 3'd0;
            y_r   <= 3'd0;
        end else if (adv) begin
            if (end_lcu) begin
                col_r <= 6'd0;
                row_r <= 6'd0;
                x_r   <= nx_s;
                y_r   <= ny_s;
            end else if (end_row_s) begin
                col_r <= 6'd0;
                row_r <= row_r + 6'd1;
            end else begin
                col_r <= col_r + 6'd1;
            end
        end
    end
endmodule

// File: rtl/ipf_lcu_feeder.sv
// Frame feeder: fetches each LCU's parameters, then streams its pixels
// row-major into the filter, stalling read issue on busy.
module ipf_lcu_feeder
    import ipf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    ipf_lcu_feeder_if.master bus
);
    state_e              state_r;
    lcu_size_e           size_r;
    logic                img_rd_r;
    logic [ADDR_W-1:0]   img_addr_r;
    logic                param_rd_r;
    logic [PARAM_AW-1:0] param_addr_r;
    logic                in_en_r;
    logic [PIX_W-1:0]    din_last_r;
    logic [1:0]          type_r;
    logic [4:0]          band_r;
    logic                wo_r;
    logic [15:0]         off_r;
    logic [2:0]          lcux_r;
    logic [2:0]          lcuy_r;
    logic                done_r;
    logic                pq_live_r;
    logic [PQ_W-1:0]     param_hold_r;

    logic                clr_s;
    logic                adv_s;
    logic [PQ_W-1:0]     pword_s;
    logic [2:0]          ag_x_s;
    logic [2:0]          ag_y_s;
    logic                end_lcu_s;
    logic                end_frame_s;
    logic [ADDR_W-1:0]   pix_addr_s;
    logic [PARAM_AW-1:0] nxt_idx_s;

    ipf_lcu_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .size      (size_r),
        .clr       (clr_s),
        .adv       (adv_s),
        .lcu_x     (ag_x_s),
        .lcu_y     (ag_y_s),
        .end_lcu   (end_lcu_s),
        .end_frame (end_frame_s),
        .pix_addr  (pix_addr_s),
        .nxt_idx   (nxt_idx_s)
    );

    // Counter control; param_q is only live the cycle after PFETCH, later PLOAD cycles use the held copy.
    always_comb begin
        clr_s   = 1'b0;
        adv_s   = 1'b0;
        pword_s = param_hold_r;
        if (state_r == S_IDLE) begin
            clr_s = bus.start;
        end else begin
            clr_s = 1'b0;
        end
        if (((state_r == S_PLOAD) || (state_r == S_STREAM)) && !bus.busy) begin
            adv_s = 1'b1;
        end else begin
            adv_s = 1'b0;
        end
        if (pq_live_r) begin
            pword_s = bus.param_q;
        end else begin
            pword_s = param_hold_r;
        end
    end

    // Frame sequencing FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            size_r       <= LCU16;
            img_rd_r     <= 1'b0;
            img_addr_r   <= '0;
            param_rd_r   <= 1'b0;
            param_addr_r <= '0;
            in_en_r      <= 1'b0;
            din_last_r   <= '0;
            type_r       <= 2'd0;
            band_r       <= 5'd0;
            wo_r         <= 1'b0;
            off_r        <= 16'd0;
            lcux_r       <= 3'd0;
            lcuy_r       <= 3'd0;
            done_r       <= 1'b0;
            pq_live_r    <= 1'b0;
            param_hold_r <= '0;
        end else begin
            in_en_r    <= img_rd_r;
            img_rd_r   <= 1'b0;
            param_rd_r <= 1'b0;
            done_r     <= 1'b0;
            pq_live_r  <= 1'b0;
            if (in_en_r) begin
                din_last_r <= bus.img_q;
            end
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        size_r       <= size_norm(bus.cfg_lcu_size);
                        param_rd_r   <= 1'b1;
                        param_addr_r <= '0;
                        state_r      <= S_PFETCH;
                    end
                end
                S_PFETCH: begin
                    pq_live_r <= 1'b1;
                    state_r   <= S_PLOAD;
                end
                S_PLOAD: begin
                    param_hold_r <= pword_s;
                    if (!bus.busy) begin
                        type_r     <= pword_s[PQ_TYPE_LSB +: PQ_TYPE_W];
                        band_r     <= pword_s[PQ_BAND_LSB +: PQ_BAND_W];
                        wo_r       <= pword_s[PQ_WO_BIT];
                        off_r      <= pword_s[PQ_OFF_LSB +: PQ_OFF_W];
                        lcux_r     <= ag_x_s;
                        lcuy_r     <= ag_y_s;
                        img_rd_r   <= 1'b1;
                        img_addr_r <= pix_addr_s;
                        state_r    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (!bus.busy) begin
                        img_rd_r   <= 1'b1;
                        img_addr_r <= pix_addr_s;
                        if (end_frame_s) begin
                            state_r <= S_DRAIN;
                        end else if (end_lcu_s) begin
                            param_rd_r   <= 1'b1;
                            param_addr_r <= nxt_idx_s;
                            state_r      <= S_PFETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    // Final read is out on the bus this cycle; done lands as its pixel is delivered.
                    if (!img_rd_r) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.img_rd       = img_rd_r;
    assign bus.img_addr     = img_addr_r;
    assign bus.param_rd     = param_rd_r;
    assign bus.param_addr   = param_addr_r;
    assign bus.in_en        = in_en_r;
    assign bus.din          = in_en_r ? bus.img_q : din_last_r;
    assign bus.ipf_type     = type_r;
    assign bus.ipf_band_pos = band_r;
    assign bus.ipf_wo_class = wo_r;
    assign bus.ipf_offset   = off_r;
    assign bus.lcu_x        = lcux_r;
    assign bus.lcu_y        = lcuy_r;
    assign bus.lcu_size     = size_r;
    assign bus.done         = done_r;
endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Bench for ipf_lcu_feeder: SRAM models, a loop-nest reference of the LCU
// raster order, and a negedge monitor that checks every read and pixel.
module tb_ipf_lcu_feeder;
    logic clk;
    logic reset;
    ipf_lcu_feeder_if bus ();

    ipf_lcu_feeder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic [7:0]  pix;
        logic [23:0] pw;
        logic [2:0]  lx;
        logic [2:0]  ly;
        bit          first;
        int          idx;
    } pix_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  img_mem [0:16383];
    logic [23:0] par_mem [0:63];
    pix_t        exp_pix_q[$];
    int          exp_addr_q[$];
    int          exp_par_q[$];
    int          rd_log[$];
    int          par_log[$];
    int          en_cnt, par_cnt, done_cnt, last_rd_cyc, done_cyc, idle_run, trail;
    pix_t        mon_e;
    logic [29:0] prev_sb;
    logic [4:0]  snap_band [0:63];
    logic [2:0]  snap_x [0:63];
    logic [2:0]  snap_y [0:63];
    logic [63:0] outs_s;
    logic [29:0] sb_s;

    assign outs_s = {bus.img_rd, bus.img_addr, bus.param_rd, bus.param_addr, bus.in_en, bus.din,
                     bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset,
                     bus.lcu_x, bus.lcu_y, bus.lcu_size, bus.done};
    assign sb_s = {bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset, bus.lcu_x, bus.lcu_y};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: data valid the cycle after the read strobe, held otherwise.
    always @(posedge clk) begin
        if (reset) begin
            bus.img_q   <= 8'd0;
            bus.param_q <= 24'd0;
        end else begin
            if (bus.img_rd)   bus.img_q   <= img_mem[bus.img_addr];
            if (bus.param_rd) bus.param_q <= par_mem[bus.param_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: LCUs in raster order, pixels row-major inside each LCU.
    task automatic build_model(input int sz);
        int n;
        int a;
        pix_t e;
        n = 128 / sz;
        exp_pix_q.delete();
        exp_addr_q.delete();
        exp_par_q.delete();
        for (int ly = 0; ly < n; ly++) begin
            for (int lx = 0; lx < n; lx++) begin
                exp_par_q.push_back(ly * n + lx);
                for (int r = 0; r < sz; r++) begin
                    for (int c = 0; c < sz; c++) begin
                        a = (ly * sz + r) * 128 + lx * sz + c;
                        exp_addr_q.push_back(a);
                        e.pix   = img_mem[a];
                        e.pw    = par_mem[ly * n + lx];
                        e.lx    = 3'(lx);
                        e.ly    = 3'(ly);
                        e.first = (r == 0) && (c == 0);
                        e.idx   = ly * n + lx;
                        exp_pix_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic start_frame(input logic [1:0] code);
        build_model((code == 2'd0) ? 16 : ((code == 2'd1) ? 32 : 64));
        rd_log.delete();
        par_log.delete();
        en_cnt = 0; par_cnt = 0; done_cnt = 0; idle_run = 0;
        last_rd_cyc = 0; done_cyc = 0; prev_sb = '0;
        @(negedge clk);
        bus.cfg_lcu_size = code;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_en(input int target);
        int k = 0;
        while (en_cnt < target && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_en_timeout", 64'(en_cnt >= target), 64'd1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", 64'(done_cnt > 0), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every param read, image read and delivered pixel against the reference.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.param_rd) begin
                par_cnt++;
                par_log.push_back(int'(bus.param_addr));
                chk("param_avail", 64'(exp_par_q.size() > 0), 64'd1);
                if (exp_par_q.size() > 0) chk("param_addr", 64'(bus.param_addr), 64'(exp_par_q.pop_front()));
            end
            if (bus.img_rd) begin
                rd_log.push_back(int'(bus.img_addr));
                last_rd_cyc = cyc;
                chk("rd_avail", 64'(exp_addr_q.size() > 0), 64'd1);
                if (exp_addr_q.size() > 0) chk("img_addr", 64'(bus.img_addr), 64'(exp_addr_q.pop_front()));
            end
            if (bus.in_en) begin
                en_cnt++;
                chk("pix_avail", 64'(exp_pix_q.size() > 0), 64'd1);
                if (exp_pix_q.size() > 0) begin
                    mon_e = exp_pix_q.pop_front();
                    chk("din", 64'(bus.din), 64'(mon_e.pix));
                    chk("sideband", 64'(sb_s), 64'({mon_e.pw, mon_e.lx, mon_e.ly}));
                    if (mon_e.first) begin
                        chk("sb_lead", 64'(prev_sb), 64'({mon_e.pw, mon_e.lx, mon_e.ly}));
                        if (mon_e.idx > 0) chk("lcu_gap", 64'(idle_run), 64'd1);
                        snap_band[mon_e.idx] = bus.ipf_band_pos;
                        snap_x[mon_e.idx]    = bus.lcu_x;
                        snap_y[mon_e.idx]    = bus.lcu_y;
                    end
                end
                idle_run = 0;
            end else begin
                idle_run++;
            end
            prev_sb = sb_s;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.cfg_lcu_size = 2'd0;
        bus.busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs_s, 64'd0);
        reset = 1'b0;

        // Size 16, pixel = addr[7:0], with a 5-cycle busy window inside LCU 0.
        for (int i = 0; i < 16384; i++) img_mem[i] = 8'(i);
        for (int i = 0; i < 64; i++) par_mem[i] = 24'($urandom);
        start_frame(2'd0);
        wait_en(40);
        bus.busy = 1'b1;
        trail = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.in_en) trail++;
            if (k == 5) bus.busy = 1'b0;
        end
        chk("busy_trail", 64'(trail), 64'd1);
        wait_done();
        for (int k = 0; k <= 16; k++) chk("first_addrs", 64'(rd_log[k]), 64'((k < 16) ? k : 128));
        chk("rd_count", 64'(rd_log.size()), 64'd16384);
        chk("lcu1_first", 64'(rd_log[256]), 64'd16);
        chk("last_addr", 64'(rd_log[16383]), 64'd16383);
        chk("in_en_count", 64'(en_cnt), 64'd16384);
        chk("param_count16", 64'(par_cnt), 64'd64);
        chk("done_delay", 64'(done_cyc - last_rd_cyc), 64'd2);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("model_drained", 64'(exp_pix_q.size()), 64'd0);

        // Size 32 with a structured parameter table.
        for (int i = 0; i < 16384; i++) img_mem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) par_mem[i] = {2'd1, 5'(i), 1'b0, 16'h1234};
        start_frame(2'd1);
        wait_done();
        chk("lcu4_addr", 64'(rd_log[4096]), 64'd4096);
        chk("lcu4_band", 64'(snap_band[4]), 64'd4);
        chk("lcu4_x", 64'(snap_x[4]), 64'd0);
        chk("lcu4_y", 64'(snap_y[4]), 64'd1);
        chk("in_en_count32", 64'(en_cnt), 64'd16384);
        chk("param_count32", 64'(par_cnt), 64'd16);

        // Code 11 runs as 64; a start pulse mid-stream is ignored.
        for (int i = 0; i < 64; i++) par_mem[i] = 24'($urandom);
        start_frame(2'd3);
        chk("lcu_size_norm", 64'(bus.lcu_size), 64'd2);
        wait_en(1000);
        @(negedge clk);
        bus.cfg_lcu_size = 2'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        chk("in_en_count11", 64'(en_cnt), 64'd16384);
        chk("param_count11", 64'(par_cnt), 64'd4);
        chk("done_count11", 64'(done_cnt), 64'd1);
        chk("lcu_size_hold", 64'(bus.lcu_size), 64'd2);

        // Reset mid-LCU, then replay a size-64 frame from the top.
        start_frame(2'd0);
        wait_en(300);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_async", outs_s, 64'd0);
        @(posedge clk);
        #1;
        chk("reset_edge", outs_s, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        start_frame(2'd2);
        wait_done();
        chk("replay_param0", 64'(par_log[0]), 64'd0);
        chk("replay_addr0", 64'(rd_log[0]), 64'd0);
        chk("param_count64", 64'(par_cnt), 64'd4);
        chk("lcu3_row1", 64'(rd_log[3 * 4096 + 64]), 64'd8384);
        chk("in_en_count64", 64'(en_cnt), 64'd16384);
        chk("done_count64", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
